statepack_tx: RTL

STATEPACK_TX -- requirements
Module: statepack_tx

---
 rtl/statepack_pkg.sv | 30 +++
 rtl/crc32_d8.sv | 20 ++
 rtl/statepack_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/statepack_pkg.sv
// rtl/statepack_pkg.sv - shared state encodings, framing bytes and CRC-32 constants
package statepack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_TYPE = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_FCS  = 3'd5,
    ST_GAP  = 3'd6
  } state_e;

  localparam logic [7:0]  PRE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE   = 8'hD5;

  localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  // The LSB-first shift register needs the bit-reversed polynomial.
  function automatic logic [31:0] refl32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY_REFL = refl32(CRC_POLY);

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - one-byte combinational update of a reflected CRC-32
module crc32_d8
  import statepack_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // Fold the byte in, then run eight LSB-first shift/xor steps.
  always_comb begin
    logic [31:0] c;
    c = crc_i ^ {24'd0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/statepack_tx.sv
// rtl/statepack_tx.sv - framed byte serializer: preamble, type, length, payload, CRC-32 FCS, gap
module statepack_tx
  import statepack_pkg::*;
#(
  parameter int CTRL_PKT_LEN = 64,
  parameter int PRE_NUM      = 9,
  parameter int IFG_LEN      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [7:0]  tx_type,
  input  logic [15:0] tx_len,
  input  logic [7:0]  din,
  output logic        din_rdy,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_err,
  output logic [2:0]  state_c
);

  state_e      state_q;
  logic [7:0]  type_q;
  logic [15:0] len_q;
  logic [15:0] rem_q;
  logic [15:0] cnt_q;
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] fcs_shift;
  logic [7:0]  dout_q;
  logic        dout_vld_q;
  logic        din_rdy_q;
  logic        busy_q;
  logic        tx_done_q;
  logic        tx_err_q;
  logic        start_bad;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (din),
    .crc_o  (crc_d)
  );

  // FCS byte cnt_q of the finished checksum, least significant first.
  assign fcs_shift = (crc_q ^ CRC_XOROUT) >> {cnt_q[1:0], 3'b000};
  assign start_bad = (tx_type != 8'd0) && (tx_len == 16'd0);

  // Frame sequencer: every output is a register loaded alongside the state.
  // busy_q drops in the final gap cycle so a waiting request starts right after the gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      type_q     <= 8'd0;
      len_q      <= 16'd0;
      rem_q      <= 16'd0;
      cnt_q      <= 16'd0;
      crc_q      <= CRC_INIT;
      dout_q     <= 8'd0;
      dout_vld_q <= 1'b0;
      din_rdy_q  <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      if (din_rdy_q) begin
        // Payload byte popped this cycle goes straight out and into the CRC.
        state_q   <= ST_DATA;
        dout_q    <= din;
        crc_q     <= crc_d;
        rem_q     <= rem_q - 16'd1;
        din_rdy_q <= (rem_q != 16'd1);
      end else begin
        case (state_q)
          ST_IDLE, ST_GAP: begin
            if (!busy_q) begin
              dout_q     <= 8'd0;
              dout_vld_q <= 1'b0;
              if (tx_start && start_bad) begin
                state_q  <= ST_IDLE;
                tx_err_q <= 1'b1;
              end else if (tx_start) begin
                state_q    <= ST_HEAD;
                type_q     <= tx_type;
                len_q      <= tx_len;
                rem_q      <= (tx_type == 8'd0) ? 16'(CTRL_PKT_LEN) : tx_len;
                cnt_q      <= 16'd1;
                crc_q      <= CRC_INIT;
                dout_q     <= PRE_BYTE;
                dout_vld_q <= 1'b1;
                busy_q     <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              cnt_q  <= cnt_q + 16'd1;
              busy_q <= (cnt_q + 16'd1 != 16'(IFG_LEN));
            end
          end
          ST_HEAD: begin
            if (cnt_q < 16'(PRE_NUM)) begin
              dout_q <= PRE_BYTE;
              cnt_q  <= cnt_q + 16'd1;
            end else if (cnt_q == 16'(PRE_NUM)) begin
              dout_q <= SFD_BYTE;
              cnt_q  <= cnt_q + 16'd1;
            end else begin
              state_q   <= ST_TYPE;
              dout_q    <= type_q;
              din_rdy_q <= (type_q == 8'd0);
            end
          end
          ST_TYPE: begin
            state_q <= ST_LEN;
            dout_q  <= len_q[15:8];
          end
          ST_LEN: begin
            dout_q    <= len_q[7:0];
            din_rdy_q <= 1'b1;
          end
          ST_DATA: begin
            state_q <= ST_FCS;
            dout_q  <= crc_q[7:0] ^ CRC_XOROUT[7:0];
            cnt_q   <= 16'd1;
          end
          ST_FCS: begin
            if (cnt_q == 16'd4) begin
              state_q    <= ST_GAP;
              dout_q     <= 8'd0;
              dout_vld_q <= 1'b0;
              cnt_q      <= 16'd1;
              busy_q     <= (IFG_LEN > 1);
            end else begin
              dout_q    <= fcs_shift[7:0];
              tx_done_q <= (cnt_q == 16'd3);
              cnt_q     <= cnt_q + 16'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign din_rdy  = din_rdy_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;
  assign tx_err   = tx_err_q;
  assign state_c  = state_q;

endmodule
